// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, frame geometry, the stereo sample struct,
// and small sample helpers used by the mixer, tone generators and I2S transmitter.
package audio_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int FRAME_CYCLES = 1024;
  localparam int SLOTS_PER_CH = 32;
  localparam int SLOT_W       = $clog2(SLOTS_PER_CH);
  localparam int BIT_IDX_W    = $clog2(SAMPLE_W);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // Arithmetic right shift keeping the sign: 0 = full scale, 7 = -42 dB.
  function automatic sample_t asr_sample(sample_t s, logic [2:0] sh);
    return sample_t'($signed(s) >>> sh);
  endfunction

  // I2S slot content: slot 0 is the one-bit delay, slots 1..16 carry MSB..LSB, the rest are 0.
  function automatic logic i2s_slot_bit(sample_t word, logic [SLOT_W-1:0] slot);
    logic [SLOT_W-1:0] idx;
    idx = SLOT_W'(SAMPLE_W) - slot;
    return (slot != '0 && slot <= SLOT_W'(SAMPLE_W)) ? word[idx[BIT_IDX_W-1:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame counter; codec clocks come straight from counter bits (glitch-free).
// FRAME_LOG2 must be >= 7 so that one SCK slot spans at least two clk cycles.
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int FRAME_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_start,
  output logic              bit_update
);

  localparam int SCK_LSB = FRAME_LOG2 - 7;

  logic [FRAME_LOG2-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign mclk        = cnt[1];
  assign sck         = cnt[SCK_LSB];
  assign lrck        = cnt[FRAME_LOG2-1];
  assign slot        = cnt[FRAME_LOG2-2 -: SLOT_W];
  // Last cycle of the frame, and last cycle of each SCK period (SCK falls next).
  assign frame_start = &cnt;
  assign bit_update  = &cnt[SCK_LSB:0];

endmodule

// File: rtl/audio_i2s_tx.sv
// Double-buffered I2S transmitter: valid/ready sample intake, frame serialisation, underrun repeat.
// Optional AUDIO_I2S_VOLUME_EN adds a 3-bit volume input (arithmetic shift applied at frame load).
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter bit UNSIGNED_IN = 1'b0,
  parameter int FRAME_LOG2  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                sample_valid,
`ifdef AUDIO_I2S_VOLUME_EN
  input  logic [2:0]          volume,
`endif
  output logic                sample_ready,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin,
  output logic                underrun
);

  logic              frame_start;
  logic              bit_update;
  logic [SLOT_W-1:0] slot;

  audio_clk_gen #(.FRAME_LOG2(FRAME_LOG2)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .mclk       (audio_mclk),
    .sck        (audio_sck),
    .lrck       (audio_lrck),
    .slot       (slot),
    .frame_start(frame_start),
    .bit_update (bit_update)
  );

  stereo_t           holding;
  stereo_t           frame_reg;
  stereo_t           capture_word;
  stereo_t           load_word;
  logic              hold_full;
  logic              transfer;
  logic [SLOT_W-1:0] nxt_slot;
  logic              nxt_right;
  logic              nxt_bit;

  assign sample_ready = !hold_full;
  assign transfer     = sample_valid && sample_ready;

  // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
  always_comb begin
    capture_word.left  = left_in;
    capture_word.right = right_in;
    if (UNSIGNED_IN) begin
      capture_word.left[SAMPLE_W-1]  = ~left_in[SAMPLE_W-1];
      capture_word.right[SAMPLE_W-1] = ~right_in[SAMPLE_W-1];
    end
  end

`ifdef AUDIO_I2S_VOLUME_EN
  assign load_word.left  = asr_sample(holding.left, volume);
  assign load_word.right = asr_sample(holding.right, volume);
`else
  assign load_word = holding;
`endif

  // SDIN is loaded one slot ahead: the bit for the slot that begins after this cycle.
  assign nxt_slot  = slot + 1'b1;
  assign nxt_right = audio_lrck ^ (&slot);
  assign nxt_bit   = i2s_slot_bit(nxt_right ? frame_reg.right : frame_reg.left, nxt_slot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding    <= '0;
      frame_reg  <= '0;
      hold_full  <= 1'b0;
      audio_sdin <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= frame_start && !hold_full;
      // ready is low whenever a load empties the buffer, so load and capture never collide.
      if (frame_start && hold_full) begin
        frame_reg <= load_word;
        hold_full <= 1'b0;
      end else if (transfer) begin
        holding   <= capture_word;
        hold_full <= 1'b1;
      end
      if (bit_update) audio_sdin <= nxt_bit;
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: a signed and an offset-binary instance driven side by side
// against a frame-level reference model (slot arithmetic, sample queue, floor-division volume).
module tb_audio_i2s_tx;

  localparam int FRAME = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] left_in = '0, right_in = '0, left_u = '0, right_u = '0;
  logic        valid = 1'b0;
`ifdef AUDIO_I2S_VOLUME_EN
  logic [2:0]  volume = '0;
`endif
  logic ready, mclk, lrck, sck, sdin, und;
  logic ready_u, mclk_u, lrck_u, sck_u, sdin_u, und_u;

  audio_i2s_tx #(.UNSIGNED_IN(1'b0)) dut (
    .clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in), .sample_valid(valid),
`ifdef AUDIO_I2S_VOLUME_EN
    .volume(volume),
`endif
    .sample_ready(ready), .audio_mclk(mclk), .audio_lrck(lrck), .audio_sck(sck),
    .audio_sdin(sdin), .underrun(und)
  );

  audio_i2s_tx #(.UNSIGNED_IN(1'b1)) dut_u (
    .clk(clk), .rst(rst), .left_in(left_u), .right_in(right_u), .sample_valid(valid),
`ifdef AUDIO_I2S_VOLUME_EN
    .volume(volume),
`endif
    .sample_ready(ready_u), .audio_mclk(mclk_u), .audio_lrck(lrck_u), .audio_sck(sck_u),
    .audio_sdin(sdin_u), .underrun(und_u)
  );

  always #5 clk = ~clk;

  // Reference model state: t = clk edges since reset release (equals the frame position mod FRAME).
  int          t;
  logic [31:0] m_hold, m_hold_u, m_frame, m_frame_u;
  bit          m_full, m_und;
  int          n_chk = 0, n_fail = 0;

  function automatic logic [15:0] vol_scale(logic [15:0] w, int v);
    int x, d;
    x = int'($signed(w));
    d = 1 << v;
    x = (x < 0) ? -((-x + d - 1) / d) : x / d;
    return x[15:0];
  endfunction

  function automatic logic exp_bit(logic [31:0] word, int c);
    int slot;
    logic [15:0] w;
    slot = (c / 16) % 32;
    w = ((c / 512) % 2 == 1) ? word[15:0] : word[31:16];
    if (slot >= 1 && slot <= 16) return w[16 - slot];
    return 1'b0;
  endfunction

  function automatic logic [31:0] load(logic [31:0] h, int v);
    return {vol_scale(h[31:16], v), vol_scale(h[15:0], v)};
  endfunction

  task automatic model_reset();
    t = 0; m_hold = '0; m_hold_u = '0; m_frame = '0; m_frame_u = '0; m_full = 0; m_und = 0;
  endtask

  // Advance one clk and apply the frame-level rules; leaves the bench on the following negedge.
  task automatic tick();
    int pos, v;
    bit was_full;
    pos = t % FRAME;
    was_full = m_full;
    v = 0;
`ifdef AUDIO_I2S_VOLUME_EN
    v = int'(volume);
`endif
    @(posedge clk);
    m_und = 1'b0;
    if (pos == FRAME - 1) begin
      if (was_full) begin
        m_frame = load(m_hold, v);
        m_frame_u = load(m_hold_u, v);
        m_full = 1'b0;
      end else m_und = 1'b1;
    end
    if (valid && !was_full) begin
      m_hold = {left_in, right_in};
      m_hold_u = {left_u ^ 16'h8000, right_u ^ 16'h8000};
      m_full = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int c, pulses;
    rst = 1'b1; valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sdin, mclk, sck, lrck, und, ready} !== 6'b000001) begin
      n_fail++; $display("FAIL reset_state: got %b expected 000001", {sdin, mclk, sck, lrck, und, ready});
    end
    rst = 1'b0; model_reset();
    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(); c = t % FRAME;
      pulses += int'(und);
      n_chk++;
      if ({mclk, sck, lrck} !== {1'(c >> 1), 1'(c >> 3), 1'(c >> 9)}) begin
        n_fail++; $display("FAIL idle_clocks c=%0d: got %b", c, {mclk, sck, lrck});
      end
      n_chk++;
      if ({sdin, sdin_u, ready} !== 3'b001) begin
        n_fail++; $display("FAIL idle_sdin_ready c=%0d: got %b expected 001", c, {sdin, sdin_u, ready});
      end
    end
    n_chk++;
    if (pulses != 2) begin n_fail++; $display("FAIL idle_underrun_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_single_transfer();
    int c, slot, extra;
    logic [15:0] gw[2], gu[2];
    while (t % FRAME != 200) tick();
    left_in = 16'hA5C3; right_in = 16'h0001; left_u = 16'hFFFF; right_u = 16'hFFFF; valid = 1'b1;
    tick(); valid = 1'b0;
    while (t % FRAME != 0) begin
      n_chk++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_held c=%0d: got %b expected 0", t % FRAME, ready); end
      tick();
    end
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_load: got %b expected 1", ready); end
    extra = 0; gw = '{16'h0, 16'h0}; gu = '{16'h0, 16'h0};
    for (int i = 0; i < FRAME; i++) begin
      tick(); c = t % FRAME;
      if (c % 16 == 8) begin
        slot = (c / 16) % 32;
        if (slot >= 1 && slot <= 16) begin
          gw[c / 512] = {gw[c / 512][14:0], sdin};
          gu[c / 512] = {gu[c / 512][14:0], sdin_u};
        end else extra += int'(sdin) + int'(sdin_u);
      end
    end
    n_chk++;
    if ({gw[0], gw[1]} !== 32'hA5C3_0001) begin
      n_fail++; $display("FAIL single_word: got %h expected a5c30001", {gw[0], gw[1]});
    end
    n_chk++;
    if ({gu[0], gu[1]} !== 32'h7FFF_7FFF) begin
      n_fail++; $display("FAIL unsigned_word: got %h expected 7fff7fff", {gu[0], gu[1]});
    end
    n_chk++;
    if (extra != 0) begin n_fail++; $display("FAIL pad_slots_zero: got %0d ones expected 0", extra); end
  endtask

  task automatic test_underrun_repeat();
    int c, pulses;
    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(); c = t % FRAME;
      pulses += int'(und);
      n_chk++;
      if (und !== m_und) begin n_fail++; $display("FAIL underrun c=%0d: got %b expected %b", c, und, m_und); end
      if (c % 16 == 8) begin
        n_chk++;
        if (sdin !== exp_bit(32'hA5C3_0001, c)) begin
          n_fail++; $display("FAIL repeat_sdin c=%0d: got %b expected %b", c, sdin, exp_bit(32'hA5C3_0001, c));
        end
      end
    end
    n_chk++;
    if (pulses != 2) begin n_fail++; $display("FAIL underrun_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_back_to_back();
    int c, xfers;
    logic [31:0] first;
    while (t % FRAME != 100) tick();
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      left_in = 16'($urandom); right_in = 16'($urandom); left_u = left_in; right_u = right_in;
      if (i == 0) first = {left_in, right_in};
      valid = 1'b1;
      xfers += int'(valid && ready);
      tick();
      n_chk++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready i=%0d: got %b expected 0", i, ready); end
    end
    valid = 1'b0;
    n_chk++;
    if (xfers != 1) begin n_fail++; $display("FAIL b2b_transfers: got %0d expected 1", xfers); end
    while (t % FRAME != 0) tick();
    for (int i = 0; i < FRAME; i++) begin
      tick(); c = t % FRAME;
      if (c % 16 == 8) begin
        n_chk++;
        if (sdin !== exp_bit(first, c)) begin
          n_fail++; $display("FAIL b2b_sdin c=%0d: got %b expected %b", c, sdin, exp_bit(first, c));
        end
      end
    end
  endtask

  task automatic test_random();
    int c, at, len;
    bit send;
    for (int f = 0; f < 6; f++) begin
      send = ($urandom_range(3) != 0);
      at = $urandom_range(1000);
      len = $urandom_range(4, 1);
`ifdef AUDIO_I2S_VOLUME_EN
      volume = 3'($urandom);
`endif
      for (int i = 0; i < FRAME; i++) begin
        valid = send && i >= at && i < at + len;
        left_in = 16'($urandom); right_in = 16'($urandom); left_u = 16'($urandom); right_u = 16'($urandom);
        tick(); c = t % FRAME;
        n_chk++;
        if ({ready, und} !== {!m_full, m_und}) begin
          n_fail++; $display("FAIL rand_ready_und c=%0d: got %b expected %b", c, {ready, und}, {!m_full, m_und});
        end
        if (c % 16 == 8) begin
          n_chk++;
          if ({sdin, sdin_u} !== {exp_bit(m_frame, c), exp_bit(m_frame_u, c)}) begin
            n_fail++; $display("FAIL rand_sdin c=%0d: got %b expected %b", c, {sdin, sdin_u},
                               {exp_bit(m_frame, c), exp_bit(m_frame_u, c)});
          end
        end
      end
    end
    valid = 1'b0;
`ifdef AUDIO_I2S_VOLUME_EN
    volume = '0;
`endif
  endtask

`ifdef AUDIO_I2S_VOLUME_EN
  task automatic test_volume();
    int c, slot;
    logic [15:0] gw[2];
    while (t % FRAME != 100 || m_full) tick();
    volume = 3'd3; left_in = 16'h8000; right_in = 16'h1234; left_u = 16'h0; right_u = 16'h0; valid = 1'b1;
    tick(); valid = 1'b0;
    while (t % FRAME != 0) tick();
    gw = '{16'h0, 16'h0};
    for (int i = 0; i < FRAME; i++) begin
      tick(); c = t % FRAME; slot = (c / 16) % 32;
      if (c % 16 == 8 && slot >= 1 && slot <= 16) gw[c / 512] = {gw[c / 512][14:0], sdin};
    end
    volume = '0;
    n_chk++;
    if ({gw[0], gw[1]} !== 32'hF000_0246) begin
      n_fail++; $display("FAIL volume_word: got %h expected f0000246", {gw[0], gw[1]});
    end
  endtask
`endif

  task automatic test_reset_mid();
    int c;
    while (t % FRAME != 100 || m_full) tick();
    left_in = 16'hFFFF; right_in = 16'hFFFF; left_u = 16'hFFFF; right_u = 16'hFFFF; valid = 1'b1;
    tick(); valid = 1'b0;
    while (t % FRAME != 600 || m_full) tick();
    n_chk++;
    if ({sdin, sdin_u, sck, lrck} !== 4'b1111) begin
      n_fail++; $display("FAIL pre_reset c=600: got %b expected 1111", {sdin, sdin_u, sck, lrck});
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({sdin, sdin_u, mclk, sck, lrck, und, ready} !== 7'b0000001) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b expected 0000001", {sdin, sdin_u, mclk, sck, lrck, und, ready});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; model_reset();
    for (int i = 0; i < FRAME + 64; i++) begin
      tick(); c = t % FRAME;
      n_chk++;
      if ({mclk, sck, lrck, sdin, sdin_u, und} !== {1'(c >> 1), 1'(c >> 3), 1'(c >> 9), 2'b00, m_und}) begin
        n_fail++; $display("FAIL restart c=%0d: got %b expected %b", c, {mclk, sck, lrck, sdin, sdin_u, und},
                           {1'(c >> 1), 1'(c >> 3), 1'(c >> 9), 2'b00, m_und});
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_transfer();
    test_underrun_repeat();
    test_back_to_back();
    test_random();
`ifdef AUDIO_I2S_VOLUME_EN
    test_volume();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
